// File: rtl/bakery_pkg.sv
// Shared types for the bounded-ticket bakery mutual-exclusion model.
// Holds the per-process location encoding and the largest-ticket helper.
package bakery_pkg;

    typedef enum logic [3:0] {
        NCS,
        TAKE,
        STALL,
        DOORWAY_END,
        SCAN_INIT,
        SCAN_TEST,
        WAIT_CHOOSE,
        WAIT_TICKET,
        SCAN_NEXT,
        CRIT,
        EXIT,
        EXIT_WAIT
    } loc_t;

    function automatic int unsigned tkmax(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/bakery_ticket_max.sv
// Unsigned maximum over all process tickets.
// Purely combinational, zero latency, no flow control.
module bakery_ticket_max #(
    parameter int NPROC = 3,
    parameter int TKW   = 3
) (
    input  logic [NPROC-1:0][TKW-1:0] tickets,
    output logic [TKW-1:0]            max_tk
);

    always_comb begin
        max_tk = '0;
        for (int i = 0; i < NPROC; i++) begin
            if (tickets[i] > max_tk) max_tk = tickets[i];
        end
    end

endmodule

// File: rtl/bakery_bounded.sv
// NPROC-process bakery protocol with bounded tickets; a doorway stall replaces wrap.
// One selected process steps per clock; outputs registered alongside pc; no backpressure.
module bakery_bounded
    import bakery_pkg::*;
#(
    parameter int NPROC = 3,
    parameter int TKW   = 3,
    parameter int SELW  = 2,
    parameter int CNTW  = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [SELW-1:0]  select,
    input  logic             pause,
    output logic [NPROC-1:0] crit,
    output logic [NPROC-1:0] stall,
    output logic             mutex_err,
    output logic [CNTW-1:0]  grant_cnt
);

    localparam logic [TKW-1:0] TKMAX   = TKW'(tkmax(TKW));
    localparam logic [SELW:0]  NPROC_W = (SELW+1)'(NPROC);

    loc_t             pc       [NPROC];
    logic [TKW-1:0]   ticket   [NPROC];
    logic [NPROC-1:0] choosing;
    // j carries one extra bit so the scan end is never aliased to index 0
    logic [SELW:0]    j        [NPROC];
    logic [SELW-1:0]  k;

    logic [NPROC-1:0][TKW-1:0] tk_packed;
    logic [TKW-1:0]            tk_max;

    always_comb begin
        for (int i = 0; i < NPROC; i++) tk_packed[i] = ticket[i];
    end

    bakery_ticket_max #(
        .NPROC (NPROC),
        .TKW   (TKW)
    ) u_ticket_max (
        .tickets (tk_packed),
        .max_tk  (tk_max)
    );

    logic            step;
    logic [SELW-1:0] p;
    logic [SELW-1:0] jl;
    logic [TKW-1:0]  tk_k;
    logic [TKW-1:0]  tk_p;
    loc_t            pc_cur;
    loc_t            pc_nxt;
    logic [TKW-1:0]  tk_nxt;
    logic            ch_nxt;
    logic [SELW:0]   j_nxt;
    logic [SELW-1:0] k_nxt;
    logic            enter_crit;
    logic [NPROC-1:0] crit_nxt;
    logic [NPROC-1:0] stall_nxt;

    assign step = {1'b0, select} < NPROC_W;
    assign p    = step ? select : '0;
    assign jl   = j[p][SELW-1:0];
    assign tk_k = ticket[jl];
    assign tk_p = ticket[p];

    always_comb begin
        pc_cur = pc[p];
        pc_nxt = pc[p];
        tk_nxt = ticket[p];
        ch_nxt = choosing[p];
        j_nxt  = j[p];
        k_nxt  = k;
        case (pc_cur)
            NCS: begin
                ch_nxt = 1'b1;
                pc_nxt = TAKE;
            end
            TAKE: begin
                if (tk_max == TKMAX) begin
                    ch_nxt = 1'b0;
                    tk_nxt = '0;
                    pc_nxt = STALL;
                end else begin
                    tk_nxt = tk_max + 1'b1;
                    pc_nxt = DOORWAY_END;
                end
            end
            STALL: begin
                if (tk_max < TKMAX) begin
                    ch_nxt = 1'b1;
                    pc_nxt = TAKE;
                end
            end
            DOORWAY_END: begin
                ch_nxt = 1'b0;
                pc_nxt = SCAN_INIT;
            end
            SCAN_INIT: begin
                j_nxt  = '0;
                pc_nxt = SCAN_TEST;
            end
            SCAN_TEST: pc_nxt = (j[p] < NPROC_W) ? WAIT_CHOOSE : CRIT;
            WAIT_CHOOSE: begin
                k_nxt = jl;
                if (!choosing[jl]) pc_nxt = WAIT_TICKET;
            end
            WAIT_TICKET: begin
                k_nxt = jl;
                if (!((tk_k != '0) &&
                      ((tk_k < tk_p) || ((tk_k == tk_p) && (jl < p)))))
                    pc_nxt = SCAN_NEXT;
            end
            SCAN_NEXT: begin
                j_nxt  = j[p] + 1'b1;
                pc_nxt = SCAN_TEST;
            end
            CRIT: if (!pause) pc_nxt = EXIT;
            EXIT: begin
                tk_nxt = '0;
                pc_nxt = EXIT_WAIT;
            end
            EXIT_WAIT: if (!pause) pc_nxt = NCS;
            default: pc_nxt = NCS;
        endcase
    end

    assign enter_crit = step && (pc_cur == SCAN_TEST) && (pc_nxt == CRIT);

    always_comb begin
        crit_nxt  = '0;
        stall_nxt = '0;
        for (int i = 0; i < NPROC; i++) begin
            if (step && (SELW'(i) == p)) begin
                crit_nxt[i]  = (pc_nxt == CRIT);
                stall_nxt[i] = (pc_nxt == STALL);
            end else begin
                crit_nxt[i]  = (pc[i] == CRIT);
                stall_nxt[i] = (pc[i] == STALL);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NPROC; i++) begin
                pc[i]     <= NCS;
                ticket[i] <= '0;
                j[i]      <= '0;
            end
            choosing  <= '0;
            k         <= '0;
            crit      <= '0;
            stall     <= '0;
            mutex_err <= 1'b0;
            grant_cnt <= '0;
        end else begin
            if (step) begin
                pc[p]       <= pc_nxt;
                ticket[p]   <= tk_nxt;
                choosing[p] <= ch_nxt;
                j[p]        <= j_nxt;
                k           <= k_nxt;
            end
            crit  <= crit_nxt;
            stall <= stall_nxt;
            if ((crit & (crit - 1'b1)) != '0) mutex_err <= 1'b1;
            if (enter_crit && (grant_cnt != {CNTW{1'b1}})) grant_cnt <= grant_cnt + 1'b1;
        end
    end

    k_in_range: assert property (@(posedge clock) disable iff (!reset_n)
        ({1'b0, k} < NPROC_W));

endmodule

// File: tb/tb_bakery_bounded.sv
// Directed and table-driven bench for bakery_bounded (NPROC=3, TKW=3, CNTW=4).
module tb_bakery_bounded;
    import bakery_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] select = 2'd3;
    logic       pause = 1'b0;
    logic [2:0] crit;
    logic [2:0] stall;
    logic       mutex_err;
    logic [3:0] grant_cnt;

    int checks = 0;
    int errors = 0;

    bakery_bounded #(.NPROC(3), .TKW(3), .SELW(2), .CNTW(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .select    (select),
        .pause     (pause),
        .crit      (crit),
        .stall     (stall),
        .mutex_err (mutex_err),
        .grant_cnt (grant_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] sel;
        logic       pz;
        logic [2:0] crit;
        logic [2:0] stall;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl [24];

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_step(input logic [1:0] s, input logic pz);
        select = s;
        pause  = pz;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        select  = 2'd3;
        pause   = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic run_to_crit(input logic [1:0] pr, output int n);
        n = 0;
        while (!crit[pr] && n < 64) begin
            do_step(pr, 1'b0);
            n++;
        end
        check("crit reached within budget", int'(crit[pr]), 1);
    endtask

    task automatic leave_crit(input logic [1:0] pr);
        repeat (3) do_step(pr, 1'b0);
    endtask

    task automatic take(input logic [1:0] pr);
        repeat (3) do_step(pr, 1'b0);
    endtask

    initial begin
        int n;
        int holder;
        int other;
        int exp_tk;
        int model_cnt;
        logic [2:0] prev_crit;
        logic [1:0] rs;
        logic       rp;
        int viol;

        for (int i = 0; i < 16; i++) tbl[i] = '{2'd0, 1'b0, 3'b000, 3'b000, 4'd0};
        tbl[16] = '{2'd0, 1'b0, 3'b001, 3'b000, 4'd1};
        tbl[17] = '{2'd0, 1'b1, 3'b001, 3'b000, 4'd1};
        tbl[18] = '{2'd3, 1'b0, 3'b001, 3'b000, 4'd1};
        tbl[19] = '{2'd0, 1'b0, 3'b000, 3'b000, 4'd1};
        tbl[20] = '{2'd0, 1'b0, 3'b000, 3'b000, 4'd1};
        tbl[21] = '{2'd0, 1'b1, 3'b000, 3'b000, 4'd1};
        tbl[22] = '{2'd0, 1'b0, 3'b000, 3'b000, 4'd1};
        tbl[23] = '{2'd3, 1'b0, 3'b000, 3'b000, 4'd1};

        // reset state
        apply_reset();
        check("reset crit", crit, 0);
        check("reset stall", stall, 0);
        check("reset mutex_err", mutex_err, 0);
        check("reset grant_cnt", grant_cnt, 0);

        // solo process 0 walk: CRIT on the 17th selected step
        for (int i = 0; i < 24; i++) begin
            do_step(tbl[i].sel, tbl[i].pz);
            check($sformatf("vec%0d crit", i), crit, tbl[i].crit);
            check($sformatf("vec%0d stall", i), stall, tbl[i].stall);
            check($sformatf("vec%0d grant_cnt", i), grant_cnt, tbl[i].cnt);
            if (i == 16) check("solo ticket0", dut.ticket[0], 1);
        end

        // contention: p0 then p1 take tickets 1 and 2
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            do_step(2'd0, 1'b0);
            do_step(2'd1, 1'b0);
        end
        check("contend crit p0", crit, 3'b001);
        check("contend ticket0", dut.ticket[0], 1);
        check("contend ticket1", dut.ticket[1], 2);
        repeat (20) do_step(2'd1, 1'b1);
        check("p1 blocked crit", crit, 3'b001);
        leave_crit(2'd0);
        check("p0 left crit", crit, 3'b000);
        check("p0 ticket cleared", dut.ticket[0], 0);
        run_to_crit(2'd1, n);
        check("p1 steps after release", n, 11);
        check("p1 crit", crit, 3'b010);
        check("contend grant_cnt", grant_cnt, 2);
        check("contend mutex_err", mutex_err, 0);

        // ticket climb to TKMAX and doorway stall
        apply_reset();
        run_to_crit(2'd0, n);
        check("climb ticket0", dut.ticket[0], 1);
        take(2'd1);
        check("climb ticket1", dut.ticket[1], 2);
        holder = 0;
        other  = 1;
        exp_tk = 2;
        for (int r = 0; r < 5; r++) begin
            leave_crit(2'(holder));
            take(2'(holder));
            exp_tk++;
            check($sformatf("climb round%0d ticket", r), dut.ticket[holder], exp_tk);
            run_to_crit(2'(other), n);
            holder = other;
            other  = 1 - other;
        end
        check("climb holder crit", crit, 3'b010);
        do_step(2'd2, 1'b0);
        do_step(2'd2, 1'b0);
        check("p2 enters stall", stall, 3'b100);
        check("p2 stall ticket", dut.ticket[2], 0);
        do_step(2'd2, 1'b0);
        check("p2 holds stall", stall, 3'b100);
        leave_crit(2'd1);
        do_step(2'd2, 1'b0);
        check("p2 stall while t0=7", stall, 3'b100);
        run_to_crit(2'd0, n);
        check("p0 crit with t=7", crit, 3'b001);
        check("stall during p0 crit", stall, 3'b100);
        leave_crit(2'd0);
        do_step(2'd2, 1'b0);
        check("p2 leaves stall", stall, 3'b000);
        do_step(2'd2, 1'b0);
        check("p2 retake ticket", dut.ticket[2], 1);
        check("climb grant_cnt", grant_cnt, 7);
        check("climb mutex_err", mutex_err, 0);

        // asynchronous reset while p1 is in CRIT
        apply_reset();
        run_to_crit(2'd1, n);
        check("p1 solo latency", n, 17);
        #3 reset_n = 1'b0;
        #1;
        check("async crit", crit, 0);
        check("async stall", stall, 0);
        check("async grant_cnt", grant_cnt, 0);
        check("async ticket1", dut.ticket[1], 0);
        for (int i = 0; i < 3; i++) check($sformatf("async pc%0d", i), int'(dut.pc[i]), int'(NCS));
        apply_reset();

        // idle selects do not disturb a mid-scan process
        for (int i = 0; i < 5; i++) do_step(2'd0, 1'b0);
        for (int i = 0; i < 10; i++) do_step(2'd3, 1'b0);
        check("idle crit", crit, 0);
        check("idle grant_cnt", grant_cnt, 0);
        run_to_crit(2'd0, n);
        check("steps remaining after idle", n, 12);

        // grant counter saturation
        apply_reset();
        for (int g = 0; g < 20; g++) begin
            run_to_crit(2'd0, n);
            check($sformatf("sat grant%0d", g), grant_cnt, (g + 1 > 15) ? 15 : g + 1);
            leave_crit(2'd0);
        end

        // random interleaving
        apply_reset();
        model_cnt = 0;
        prev_crit = 3'b000;
        viol = 0;
        for (int c = 0; c < 1000; c++) begin
            rs = 2'($urandom_range(0, 3));
            rp = ($urandom_range(0, 3) == 0);
            do_step(rs, rp);
            if (((crit & ~prev_crit) != 3'b000) && model_cnt < 15) model_cnt++;
            prev_crit = crit;
            if (mutex_err || ($countones(crit) > 1)) viol++;
        end
        check("random mutex violations", viol, 0);
        check("random mutex_err", mutex_err, 0);
        check("random grant_cnt", grant_cnt, model_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
